// File: rtl/vm_dispense_pkg.sv
// Shared types for the vending machine dispense stage.
// Product indices run 1..3; 0 means no product.
package vm_dispense_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPIN,
    S_WAIT_DROP,
    S_DONE,
    S_FAULT
  } state_t;

  typedef logic [1:0] prod_idx_t;

  localparam prod_idx_t PROD_NONE = 2'd0;

  // product1 outranks product2, which outranks product3
  function automatic prod_idx_t sel_index(
    input logic p1,
    input logic p2,
    input logic p3
  );
    if (p1)
      sel_index = 2'd1;
    else if (p2)
      sel_index = 2'd2;
    else if (p3)
      sel_index = 2'd3;
    else
      sel_index = PROD_NONE;
  endfunction

  function automatic logic [2:0] idx_onehot(
    input prod_idx_t idx
  );
    case (idx)
      2'd1:    idx_onehot = 3'b001;
      2'd2:    idx_onehot = 3'b010;
      2'd3:    idx_onehot = 3'b100;
      default: idx_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vm_down_timer.sv
// Loadable down-counter shared by the motor spin and drop wait phases.
// expired is high during the last cycle of a loaded interval.
module vm_down_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - W'(1);
  end

  // a load of N gives exactly N cycles before the expiry edge
  assign expired = (count <= W'(1));

endmodule

// File: rtl/vm_dispense_controller.sv
// Dispense stage: motor drive, drop confirmation, one-deep
// request slot and per-product stock tracking.
module vm_dispense_controller
  import vm_dispense_pkg::*;
#(
  parameter int MOTOR_CYCLES = 200,
  parameter int DROP_TIMEOUT = 400,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               product1,
  input  logic               product2,
  input  logic               product3,
  input  logic               delivered,
  input  logic               drop_sensor,
  input  logic               restock,
  output logic               motor1,
  output logic               motor2,
  output logic               motor3,
  output logic               busy,
  output logic               vend_done,
  output logic               reject,
  output logic               fault,
  output logic [2:0]         sold_out,
  output logic [STOCK_W-1:0] stock1,
  output logic [STOCK_W-1:0] stock2,
  output logic [STOCK_W-1:0] stock3
);

  localparam int TMAX =
    (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_MOTOR = TW'(MOTOR_CYCLES);
  localparam logic [TW-1:0] T_DROP  = TW'(DROP_TIMEOUT);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);

  state_t    state_q, state_d;
  prod_idx_t sel_q, sel_d;
  prod_idx_t slot_q, slot_d;
  prod_idx_t req, pend;
  logic      rs_pend_q, rs_pend_d;
  logic      reload;
  logic      done_d, reject_d;
  logic      tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;
  logic [2:0] motor_q;

  logic [STOCK_W-1:0] st1_q, st2_q, st3_q;
  logic [STOCK_W-1:0] st1_d, st2_d, st3_d;

  function automatic logic [STOCK_W-1:0] stock_of(
    input prod_idx_t          idx,
    input logic [STOCK_W-1:0] a,
    input logic [STOCK_W-1:0] b,
    input logic [STOCK_W-1:0] c
  );
    case (idx)
      2'd1:    stock_of = a;
      2'd2:    stock_of = b;
      2'd3:    stock_of = c;
      default: stock_of = '0;
    endcase
  endfunction

  assign req = delivered
    ? sel_index(product1, product2, product3)
    : PROD_NONE;

  vm_down_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_val),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    slot_d    = slot_q;
    rs_pend_d = rs_pend_q;
    st1_d     = st1_q;
    st2_d     = st2_q;
    st3_d     = st3_q;
    reload    = 1'b0;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = T_MOTOR;
    // in DONE a fresh request fills an empty slot and is consumed at once
    pend = (slot_q != PROD_NONE) ? slot_q : req;

    unique case (state_q)
      S_IDLE: begin
        if (restock) begin
          reload   = 1'b1;
          reject_d = (req != PROD_NONE);
        end else if (req != PROD_NONE) begin
          if (stock_of(req, st1_q, st2_q, st3_q) != '0) begin
            sel_d    = req;
            tmr_load = 1'b1;
            state_d  = S_SPIN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_SPIN, S_WAIT_DROP: begin
        if (req != PROD_NONE) begin
          if (slot_q == PROD_NONE)
            slot_d = req;
          else
            reject_d = 1'b1;
        end
        if (restock)
          rs_pend_d = 1'b1;
        if (state_q == S_SPIN) begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = T_DROP;
            state_d  = S_WAIT_DROP;
          end
        end else if (drop_sensor) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          unique case (sel_q)
            2'd1: if (st1_q != '0) st1_d = st1_q - STOCK_W'(1);
            2'd2: if (st2_q != '0) st2_d = st2_q - STOCK_W'(1);
            2'd3: if (st3_q != '0) st3_d = st3_q - STOCK_W'(1);
            default: ;
          endcase
        end else if (tmr_expired) begin
          // anything queued is discarded on the way into FAULT
          state_d  = S_FAULT;
          slot_d   = PROD_NONE;
          reject_d = (req != PROD_NONE) || (slot_q != PROD_NONE);
        end
      end

      S_DONE: begin
        slot_d  = PROD_NONE;
        state_d = S_IDLE;
        if (slot_q != PROD_NONE && req != PROD_NONE)
          reject_d = 1'b1;
        if (restock || rs_pend_q) begin
          reload = 1'b1;
          if (pend != PROD_NONE)
            reject_d = 1'b1;
        end else if (pend != PROD_NONE) begin
          if (stock_of(pend, st1_q, st2_q, st3_q) != '0) begin
            sel_d    = pend;
            tmr_load = 1'b1;
            state_d  = S_SPIN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_FAULT: begin
        slot_d   = PROD_NONE;
        reject_d = (req != PROD_NONE);
        if (restock || rs_pend_q) begin
          reload  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      st1_d     = S_INIT;
      st2_d     = S_INIT;
      st3_d     = S_INIT;
      rs_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sel_q     <= PROD_NONE;
      slot_q    <= PROD_NONE;
      rs_pend_q <= 1'b0;
      st1_q     <= S_INIT;
      st2_q     <= S_INIT;
      st3_q     <= S_INIT;
      motor_q   <= 3'b000;
      busy      <= 1'b0;
      vend_done <= 1'b0;
      reject    <= 1'b0;
      fault     <= 1'b0;
      sold_out  <= 3'b000;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      slot_q    <= slot_d;
      rs_pend_q <= rs_pend_d;
      st1_q     <= st1_d;
      st2_q     <= st2_d;
      st3_q     <= st3_d;
      motor_q   <= (state_d == S_SPIN) ? idx_onehot(sel_d) : 3'b000;
      busy      <= (state_d != S_IDLE);
      vend_done <= done_d;
      reject    <= reject_d;
      fault     <= (state_d == S_FAULT);
      // follows the counters one cycle late
      sold_out  <= {st3_q == '0, st2_q == '0, st1_q == '0};
    end
  end

  assign motor1 = motor_q[0];
  assign motor2 = motor_q[1];
  assign motor3 = motor_q[2];
  assign stock1 = st1_q;
  assign stock2 = st2_q;
  assign stock3 = st3_q;

endmodule

// File: doc/vm_dispense_controller.md
# vm_dispense_controller

Downstream stage of the vending machine core. Consumes the core's one-hot product selection and `delivered` strobe, and drives one motor per product for a fixed spin time. It then waits for the drop sensor to confirm a vend, and keeps per-product stock counts with sold-out flags. It runs on the divided clock, in the same domain as the core, and outputs go straight to board pins and LEDs.

## Interface
- `MOTOR_CYCLES`, 200: clock cycles each motor is held on per vend (≥1).
- `DROP_TIMEOUT`, 400: cycles allowed after motor-off for `drop_sensor` to assert (≥1).
- `STOCK_W`, 4: stock counter width.
- `STOCK_INIT`, 8: value loaded into every counter on reset and on `restock` (≤2^STOCK_W−1).
- `clk`  in  1  divided system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `product1`, `product2`, `product3`  in  1 each  product selection from the core; sampled only when `delivered`=1.
- `delivered`  in  1  one-cycle vend request strobe from the core.
- `drop_sensor`  in  1  already-debounced, synchronous; 1 = item passed the chute.
- `restock`  in  1  one-cycle strobe that reloads all stock counters and clears fault.
- `motor1`, `motor2`, `motor3`  out  1 each  motor drive; at most one is high at any time.
- `busy`  out  1  high in every state except IDLE.
- `vend_done`  out  1  one-cycle pulse on a confirmed drop.
- `reject`  out  1  one-cycle pulse when a request is discarded.
- `fault`  out  1  level; the drop was not seen within the timeout.
- `sold_out`  out  3  bit i high when the stock for product i+1 is 0.
- `stock1`, `stock2`, `stock3`  out  STOCK_W each  current counts.

## Operation
- States: IDLE, SPIN, WAIT_DROP, DONE, FAULT.
- Request decode: when `delivered`=1, the selection is the highest-priority set bit, with product1 > product2 > product3. If no bit is set, the request is ignored without a reject.
- IDLE + valid request with stock > 0: latch the product index, load the timer with MOTOR_CYCLES, go to SPIN.
- IDLE + request for a product with stock 0: `reject` pulse, stay in IDLE.
- Pending slot (one deep): a valid request arriving while busy and the slot is empty is stored in the slot. If the slot is already full, `reject` pulses and the new request is dropped. In FAULT, every request is rejected.
- SPIN: the selected motor is high. When the timer expires, load DROP_TIMEOUT and go to WAIT_DROP.
- WAIT_DROP: motors are off. `drop_sensor`=1 → DONE. Timer expiry → FAULT.
- DONE (one cycle): `vend_done`=1 and the selected stock counter decrements, saturating at 0.
  - If the slot holds a product with stock > 0 after the decrement, go to SPIN for it.
  - If the slot holds a product that is now sold out, pulse `reject` and go to IDLE.
  - The slot is cleared in both cases.
- FAULT: motors off, `fault`=1, the slot is cleared. Leave only on `restock` (→ IDLE) or reset.
- `restock` in any state other than SPIN/WAIT_DROP: all counters reload to STOCK_INIT, `fault` clears, go to IDLE.
- `restock` during SPIN/WAIT_DROP: held pending and applied in the DONE or FAULT cycle.

## Timing
- Reset values: state IDLE, all motors 0, `busy`=0, `vend_done`=0, `reject`=0, `fault`=0, stock counters at STOCK_INIT, `sold_out`=000, slot empty.
- All outputs are registered.
- Request sampled at edge N → motor high from cycle N+1 through N+MOTOR_CYCLES exactly.
- `drop_sensor` high on the cycle the timer would expire counts as a drop; the sensor wins.
- `vend_done` and the stock decrement are visible in the same cycle. `sold_out` updates in the following cycle.
- A new request on the DONE cycle goes to the slot if it is empty. This is the same rule as for any busy state.
- Reset asserted mid-vend: motors drop immediately, asynchronously.

## Structure
- Package `vm_dispense_pkg` holds:
  - the state enum;
  - the 2-bit product index type (0 = none, 1–3);
  - a function that converts the one-hot selection to an index with priority applied.
- Sub-module `vm_down_timer`: a loadable down-counter with an `expired` flag, sized with $clog2 of max(MOTOR_CYCLES, DROP_TIMEOUT). It is shared between SPIN and WAIT_DROP.

## Test plan
- Reset, then `delivered` with product2=1, `drop_sensor` pulsed 10 cycles after motor-off:
  - `motor2` high for exactly 200 cycles;
  - `vend_done` pulse;
  - `stock2` goes 8 → 7.
- `delivered` with product1=1 and product3=1 together: only `motor1` runs and `stock1` decrements.
- Requests for product3 three times back-to-back while busy: the second is queued in the slot, the third gets a `reject`, and exactly two vends complete.
- Product1 vended 8 times: `sold_out[0]`=1, a ninth request gets a `reject` and no motor runs.
- No `drop_sensor` after a vend: `fault`=1 at 400 cycles, later requests are rejected, and `restock` clears the fault and sets all stocks back to 8.
- Reset asserted during SPIN: motor low at once and all outputs at their reset values.
